// File: rtl/serial_seq_detector.sv
// serial_seq_detector: serial pattern detector with saturating match count; overlap enabled by SEQ_DETECT_OVERLAP_EN
module serial_seq_detector #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);
    localparam int FW = $clog2(LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(LEN);
    typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_t;
    state_t           state_q, state_d;
    logic [LEN-1:0]   hist_q, hist_d, hist_nx;
    logic [FW-1:0]    fill_q, fill_d, fill_nx;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             det;
    // next history/fill, detection, and the fill-derived FSM state
    always_comb begin
        hist_nx = {hist_q[LEN-2:0], din};
        fill_nx = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        det     = din_valid && (fill_nx == FULL) && (hist_nx == PATTERN);
`ifdef SEQ_DETECT_OVERLAP_EN
        hist_d  = din_valid ? hist_nx : hist_q;
        fill_d  = din_valid ? fill_nx : fill_q;
`else
        hist_d  = det ? '0 : din_valid ? hist_nx : hist_q;
        fill_d  = det ? '0 : din_valid ? fill_nx : fill_q;
`endif
        state_d = (fill_d == '0) ? EMPTY : (fill_d == FULL) ? ARMED : FILLING;
        match_d = det;
        cnt_d   = (det && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    // state register with synchronous reset taking priority over input bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
        end
    end
    assign match       = match_q;
    assign match_count = cnt_q;
    assign armed       = (state_q == ARMED);
endmodule

// File: tb/tb_serial_seq_detector.sv
// tb_serial_seq_detector: directed table and corner sequences for serial_seq_detector
module tb_serial_seq_detector;
`ifdef SEQ_DETECT_OVERLAP_EN
    localparam logic OV = 1'b1;
`else
    localparam logic OV = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, din_valid = 1'b0, din = 1'b0;
    logic m0, a0, m1, a1, m2, a2;
    logic [7:0] c0, c2;
    logic [1:0] c1;
    int n_cmp = 0, n_err = 0;

    typedef struct {logic r; logic v; logic d; logic m; int c; logic a;} vec_t;
    vec_t tbl[$];

    serial_seq_detector dut0 (.clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
                              .match(m0), .match_count(c0), .armed(a0));
    serial_seq_detector #(.CNT_W(2)) dut1 (.clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
                              .match(m1), .match_count(c1), .armed(a1));
    serial_seq_detector #(.PATTERN(4'b0000)) dut2 (.clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
                              .match(m2), .match_count(c2), .armed(a2));

    always #5 clk = ~clk;

    task automatic add(input logic r, v, d, m, input int c, input logic a);
        tbl.push_back('{r, v, d, m, c, a});
    endtask

    task automatic step(input logic r, v, d);
        rst = r; din_valid = v; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        logic [3:0] p;
        int exp_c[5];
        // stream 1011011 with din_valid every cycle
        add(1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, OV);
        add(0, 1, 0, 0, 1, OV);
        add(0, 1, 1, 0, 1, OV);
        add(0, 1, 1, OV, OV ? 2 : 1, OV);
        // gaps in din_valid do not break a pattern
        add(1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, OV);
        add(0, 0, 0, 0, 1, OV);
        // reset mid-pattern discards history and the simultaneous bit
        add(1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, OV);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d);
            chk($sformatf("vec%0d match", i), 32'(m0), 32'(tbl[i].m));
            chk($sformatf("vec%0d count", i), 32'(c0), 32'(tbl[i].c));
            chk($sformatf("vec%0d armed", i), 32'(a0), 32'(tbl[i].a));
        end
        // saturating 2-bit counter over five back-to-back patterns
        exp_c = '{1, 2, 3, 3, 3};
        p = 4'b1011;
        step(1, 0, 0);
        chk("sat reset count", 32'(c1), 0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 3; i >= 0; i--) begin
                step(0, 1, p[i]);
                if (i > 0) chk($sformatf("sat%0d bit%0d match", k, i), 32'(m1), 0);
            end
            chk($sformatf("sat%0d match", k), 32'(m1), 1);
            chk($sformatf("sat%0d count", k), 32'(c1), 32'(exp_c[k]));
        end
        // all-zero pattern must not match on a partly filled history
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            chk($sformatf("zero%0d match", i), 32'(m2), 0);
            chk($sformatf("zero%0d count", i), 32'(c2), 0);
        end
        step(0, 1, 0);
        chk("zero4 match", 32'(m2), 1);
        chk("zero4 count", 32'(c2), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
